// File: rtl/mixcolumns_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mixcolumns_seq : iterative AES MixColumns, COLS_PER_CYCLE columns/clock,  |
// | valid/ready in and out. Optional InvMixColumns via MIXCOLUMNS_INV_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mixcolumns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
`ifdef MIXCOLUMNS_INV_EN
  input  logic         inv,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [1:0] c_step     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] c_last_col = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [127:0]   data_q, data_d;
  logic           w_inv_sel;

  logic [31:0]    w_mixed [COLS_PER_CYCLE];
  logic [1:0]     w_col   [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse mix = 04/05 pre-conditioning followed by the forward 02/03 matrix.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_sel);
    logic [7:0] a0, a1, a2, a3, u, v, t;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    if (inv_sel) begin
      u  = xtime(xtime(a0 ^ a2));
      v  = xtime(xtime(a1 ^ a3));
      a0 = a0 ^ u;
      a1 = a1 ^ v;
      a2 = a2 ^ u;
      a3 = a3 ^ v;
    end
    t = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xtime(a0 ^ a1),
            a1 ^ t ^ xtime(a1 ^ a2),
            a2 ^ t ^ xtime(a2 ^ a3),
            a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

`ifdef MIXCOLUMNS_INV_EN
  logic inv_q, inv_d;
  assign w_inv_sel = inv_q;
`else
  assign w_inv_sel = 1'b0;
`endif

  // Column c lives at bit offset 32*(3-c); ~c gives 3-c for a 2-bit index.
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_mixer
    assign w_col[j]   = cnt_q + 2'(j);
    assign w_mixed[j] = mix_col(data_q[{~w_col[j], 5'd0} +: 32], w_inv_sel);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
`ifdef MIXCOLUMNS_INV_EN
    inv_d     = inv_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = 2'd0;
`ifdef MIXCOLUMNS_INV_EN
          inv_d   = inv;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          data_d[{~w_col[j], 5'd0} +: 32] = w_mixed[j];
        end
        cnt_d = cnt_q + c_step;
        if (cnt_q == c_last_col) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = data_q;
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      data_q  <= '0;
`ifdef MIXCOLUMNS_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef MIXCOLUMNS_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mixcolumns_seq.sv
`default_nettype none
// Bench for mixcolumns_seq: three instances (1, 2, 4 columns per cycle) driven in
// lockstep and checked against a GF(2^8) matrix-multiply model.
module tb_mixcolumns_seq;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         out_ready;
  logic         inv_s;
  logic [127:0] in_data;
  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [127:0] od [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mixcolumns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .reset_n(reset_n),
`ifdef MIXCOLUMNS_INV_EN
    .inv(inv_s),
`endif
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0])
  );

  mixcolumns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .reset_n(reset_n),
`ifdef MIXCOLUMNS_INV_EN
    .inv(inv_s),
`endif
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1])
  );

  mixcolumns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .reset_n(reset_n),
`ifdef MIXCOLUMNS_INV_EN
    .inv(inv_s),
`endif
    .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2])
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input int d, input logic iv);
    case (d)
      0: return iv ? 8'h0e : 8'h02;
      1: return iv ? 8'h0b : 8'h03;
      2: return iv ? 8'h0d : 8'h01;
      default: return iv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic iv);
    logic [127:0] r;
    logic [7:0]   y;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        y = 8'h00;
        for (int k = 0; k < 4; k++) begin
          y = y ^ gmul(coef((k - row + 4) % 4, iv), s[127 - 32*c - 8*k -: 8]);
        end
        r[127 - 32*c - 8*row -: 8] = y;
      end
    end
    return r;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- scenarios ----------------
  task automatic run_block(input logic [127:0] din, input logic iv,
                           input logic [127:0] exp, input string tag);
    int lat [3];
    for (int i = 0; i < 3; i++) lat[i] = 0;
    in_valid = 1'b1; in_data = din; inv_s = iv;
    n_cmp++;
    if (ir !== 3'b111) begin
      n_bad++; $display("FAIL %s idle_ready: got %b want 111", tag, ir);
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = rnd128(); inv_s = ~iv;
    n_cmp++;
    if (ov !== 3'b000 || ir !== 3'b000) begin
      n_bad++; $display("FAIL %s busy_flags: got ov=%b ir=%b want 000/000", tag, ov, ir);
    end
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (lat[i] == 0 && ov[i] === 1'b1) lat[i] = e;
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (lat[i] != lat_of(i)) begin
        n_bad++; $display("FAIL %s latency[%0d]: got %0d want %0d", tag, i, lat[i], lat_of(i));
      end
      n_cmp++;
      if (od[i] !== exp) begin
        n_bad++; $display("FAIL %s data[%0d]: got %h want %h", tag, i, od[i], exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (ov !== 3'b000 || ir !== 3'b111) begin
      n_bad++; $display("FAIL %s post_handshake: got ov=%b ir=%b want 000/111", tag, ov, ir);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; inv_s = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ir !== 3'b111 || ov !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got ir=%b ov=%b want 111/000", ir, ov);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (od[i] !== 128'h0) begin
        n_bad++; $display("FAIL reset_data[%0d]: got %h want 0", i, od[i]);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vectors();
    run_block({4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}}, "vec_db13");
    run_block(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
              128'h046681e5_e0cb199a_48f8d37a_2806264c, "vec_fips");
    run_block({{2{32'h01010101}}, {2{32'hc6c6c6c6}}}, 1'b0,
              {{2{32'h01010101}}, {2{32'hc6c6c6c6}}}, "vec_ident");
  endtask

  task automatic test_random();
    logic [127:0] d;
    for (int n = 0; n < 12; n++) begin
      d = rnd128();
      run_block(d, 1'b0, ref_mix(d, 1'b0), "random");
    end
  endtask

  task automatic test_out_ready_idle();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ov !== 3'b000 || ir !== 3'b111) begin
      n_bad++; $display("FAIL idle_out_ready: got ov=%b ir=%b want 000/111", ov, ir);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_hold_and_ignore();
    logic [127:0] d, exp;
    d = rnd128();
    exp = ref_mix(d, 1'b0);
    in_valid = 1'b1; in_data = d; inv_s = 1'b0;
    @(negedge clk);
    for (int e = 0; e < 14; e++) begin
      in_data = rnd128();
      in_valid = e[0];
      @(negedge clk);
      if (e >= 3) begin
        n_cmp++;
        if (ov !== 3'b111 || ir !== 3'b000 ||
            od[0] !== exp || od[1] !== exp || od[2] !== exp) begin
          n_bad++;
          $display("FAIL hold[%0d]: got ov=%b ir=%b d0=%h d1=%h d2=%h want 111/000 %h",
                   e, ov, ir, od[0], od[1], od[2], exp);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (ov !== 3'b000 || ir !== 3'b111) begin
      n_bad++; $display("FAIL hold_release: got ov=%b ir=%b want 000/111", ov, ir);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] d;
    in_valid = 1'b1; in_data = rnd128(); inv_s = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (ir !== 3'b111 || ov !== 3'b000 ||
        od[0] !== 128'h0 || od[1] !== 128'h0 || od[2] !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_mid: got ir=%b ov=%b d0=%h want 111/000/0", ir, ov, od[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    d = rnd128();
    run_block(d, 1'b0, ref_mix(d, 1'b0), "after_reset");
  endtask

`ifdef MIXCOLUMNS_INV_EN
  task automatic test_inverse();
    logic [127:0] d;
    logic         iv;
    run_block(128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b1,
              128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, "inv_fips");
    for (int n = 0; n < 8; n++) begin
      d  = rnd128();
      iv = n[0];
      run_block(d, iv, ref_mix(d, iv), "alt_fwd_inv");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_known_vectors();
    test_out_ready_idle();
    test_random();
    test_hold_and_ignore();
    test_reset_mid_busy();
`ifdef MIXCOLUMNS_INV_EN
    test_inverse();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
